mem_responder: RTL

//   Memory-side responder for the core's load/store and instruction-fetch requests.

---
 rtl/mem_if.sv | 24 ++
 rtl/mem_responder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_if.sv
// Request/response channel between the core and mem_responder.
// The core side uses the master modport, the memory side uses the slave modport.
interface mem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding-request memory slave with programmable access latency.
// Define MEM_RESP_ERR_EN to range-check addresses and flag out-of-range accesses via resp_err.
//
// state | meaning
// IDLE  | ready to accept a request
// BUSY  | latency down-counter running
// RESP  | response presented, held until resp_ready
module mem_responder #(
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input logic   clk,
   input logic   rst,
   mem_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   generate
      if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
         $error("mem_responder: LATENCY must be in 1..255");
      end
   endgenerate

   state_t        state, state_nxt;
   logic [7:0]    cnt;
   logic          lat_wen;
   logic [63:0]   lat_addr, lat_wdata;
   logic [7:0]    lat_wstrb;
   logic [63:0]   rdata_q;
   logic          err_q;
   logic [63:0]   mem [DEPTH];

   logic          accept, enter_resp, acc_wen, acc_ok;
   logic [63:0]   acc_addr, acc_wdata, acc_off;
   logic [7:0]    acc_wstrb;
   logic [AW-1:0] acc_idx;
   logic          unused_bits;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
         BUSY: if (cnt == 8'd1) state_nxt = RESP;
         RESP: if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = rst && (state == IDLE);
      bus.resp_valid = rst && (state == RESP);
      bus.resp_rdata = rst ? rdata_q : 64'd0;
`ifdef MEM_RESP_ERR_EN
      bus.resp_err   = rst && err_q;
`else
      bus.resp_err   = 1'b0;
`endif
   end

   // With LATENCY==1 the array access coincides with the accept edge, so the
   // live request is used in IDLE and the latched copy otherwise.
   always_comb begin
      accept     = rst && (state == IDLE) && bus.req_valid;
      enter_resp = rst && (state != RESP) && (state_nxt == RESP);
      acc_wen    = (state == IDLE) ? bus.req_wen   : lat_wen;
      acc_addr   = (state == IDLE) ? bus.req_addr  : lat_addr;
      acc_wdata  = (state == IDLE) ? bus.req_wdata : lat_wdata;
      acc_wstrb  = (state == IDLE) ? bus.req_wstrb : lat_wstrb;
      acc_off    = acc_addr - BASE_ADDR;
      acc_idx    = acc_off[AW+2:3];
`ifdef MEM_RESP_ERR_EN
      acc_ok     = (acc_addr >= BASE_ADDR) && (acc_off < 64'(DEPTH) * 64'd8);
`else
      acc_ok     = 1'b1;
`endif
   end

   assign unused_bits = ^{acc_off[63:AW+3], acc_off[2:0]};

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_wen   <= bus.req_wen;
         lat_addr  <= bus.req_addr;
         lat_wdata <= bus.req_wdata;
         lat_wstrb <= bus.req_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt     <= 8'd0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         if (accept)
            cnt <= 8'(LATENCY - 1);
         else if (state == BUSY && cnt != 8'd1)
            cnt <= cnt - 8'd1;
         if (enter_resp) begin
            err_q   <= !acc_ok;
            rdata_q <= (acc_wen || !acc_ok) ? 64'd0 : mem[acc_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enter_resp && acc_wen && acc_ok) begin
         for (int i = 0; i < 8; i++) begin
            if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end
endmodule
